// File: rtl/scr1_mem_arb2.sv
// Two-port round-robin memory arbiter in front of one in-order slave.
// An ID FIFO remembers which port owns each accepted request so that responses can be routed back.
module scr1_mem_arb2 #(
    parameter int SCR1_ARB_DEPTH  = 2,
    parameter int SCR1_ARB_AWIDTH = 32,
    parameter int SCR1_ARB_DWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       p0_req,
    input  logic                       p0_cmd,
    input  logic [1:0]                 p0_width,
    input  logic [SCR1_ARB_AWIDTH-1:0] p0_addr,
    input  logic [SCR1_ARB_DWIDTH-1:0] p0_wdata,
    output logic                       p0_req_ack,
    output logic [SCR1_ARB_DWIDTH-1:0] p0_rdata,
    output logic [1:0]                 p0_resp,
    input  logic                       p1_req,
    input  logic                       p1_cmd,
    input  logic [1:0]                 p1_width,
    input  logic [SCR1_ARB_AWIDTH-1:0] p1_addr,
    input  logic [SCR1_ARB_DWIDTH-1:0] p1_wdata,
    output logic                       p1_req_ack,
    output logic [SCR1_ARB_DWIDTH-1:0] p1_rdata,
    output logic [1:0]                 p1_resp,
    output logic                       s_req,
    output logic                       s_cmd,
    output logic [1:0]                 s_width,
    output logic [SCR1_ARB_AWIDTH-1:0] s_addr,
    output logic [SCR1_ARB_DWIDTH-1:0] s_wdata,
    input  logic                       s_req_ack,
    input  logic [SCR1_ARB_DWIDTH-1:0] s_rdata,
    input  logic [1:0]                 s_resp,
    output logic                       arb_err
);

    localparam int PW = (SCR1_ARB_DEPTH > 1) ? $clog2(SCR1_ARB_DEPTH) : 1;
    localparam int CW = $clog2(SCR1_ARB_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(SCR1_ARB_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(SCR1_ARB_DEPTH - 1);
    localparam logic [1:0]    RESP_NOTRDY = 2'b00;

    logic          rr_q,      rr_d;
    logic          lock_q,    lock_d;
    logic          lock_id_q, lock_id_d;
    logic [CW-1:0] count_q,   count_d;
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic          arb_err_q, arb_err_d;
    logic          id_mem [SCR1_ARB_DEPTH];

    logic gnt_vld;
    logic gnt_id;
    logic gnt_req;
    logic full;
    logic empty;
    logic accept;
    logic resp_vld;
    logic pop;
    logic head_id;

    // A stalled request keeps ownership of the slave port until the slave accepts it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (lock_q) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else if (p0_req && p1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = rr_q;
        end else if (p0_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (p1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign gnt_req = gnt_id ? p1_req : p0_req;

    always_comb begin
        s_req   = 1'b0;
        s_cmd   = 1'b0;
        s_width = 2'b00;
        s_addr  = '0;
        s_wdata = '0;
        if (rst_n && gnt_vld) begin
            s_req   = gnt_req & ~full;
            s_cmd   = gnt_id ? p1_cmd   : p0_cmd;
            s_width = gnt_id ? p1_width : p0_width;
            s_addr  = gnt_id ? p1_addr  : p0_addr;
            s_wdata = gnt_id ? p1_wdata : p0_wdata;
        end
    end

    assign accept     = s_req & s_req_ack;
    assign p0_req_ack = accept & ~gnt_id;
    assign p1_req_ack = accept &  gnt_id;

    // Routing uses the occupancy from before this cycle, so a same-cycle push never owns the response.
    assign resp_vld = rst_n & (s_resp != RESP_NOTRDY);
    assign pop      = resp_vld & ~empty;
    assign head_id  = id_mem[rd_ptr_q];

    always_comb begin
        p0_resp  = RESP_NOTRDY;
        p0_rdata = '0;
        p1_resp  = RESP_NOTRDY;
        p1_rdata = '0;
        if (pop) begin
            if (head_id) begin
                p1_resp  = s_resp;
                p1_rdata = s_rdata;
            end else begin
                p0_resp  = s_resp;
                p0_rdata = s_rdata;
            end
        end
    end

    always_comb begin
        rr_d      = accept ? ~gnt_id : rr_q;
        lock_d    = s_req & ~s_req_ack;
        lock_id_d = gnt_id;
        arb_err_d = resp_vld & empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            arb_err_q <= arb_err_d;
        end
    end

    // Stale entries left behind by a reset are never read, since count restarts at zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_ptr_q] <= gnt_id;
        end
    end

    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_scr1_mem_arb2.sv
// Self-checking bench for scr1_mem_arb2: vector table, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_scr1_mem_arb2;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_cmd, p1_req, p1_cmd;
    logic [1:0]  p0_width, p1_width;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_req_ack, p1_req_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [1:0]  p0_resp, p1_resp;
    logic        s_req, s_cmd;
    logic [1:0]  s_width;
    logic [31:0] s_addr, s_wdata;
    logic        s_req_ack;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        arb_err;

    scr1_mem_arb2 #(
        .SCR1_ARB_DEPTH (DEPTH),
        .SCR1_ARB_AWIDTH(32),
        .SCR1_ARB_DWIDTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_cmd    (p0_cmd),
        .p0_width  (p0_width),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_req_ack(p0_req_ack),
        .p0_rdata  (p0_rdata),
        .p0_resp   (p0_resp),
        .p1_req    (p1_req),
        .p1_cmd    (p1_cmd),
        .p1_width  (p1_width),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_req_ack(p1_req_ack),
        .p1_rdata  (p1_rdata),
        .p1_resp   (p1_resp),
        .s_req     (s_req),
        .s_cmd     (s_cmd),
        .s_width   (s_width),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_req_ack (s_req_ack),
        .s_rdata   (s_rdata),
        .s_resp    (s_resp),
        .arb_err   (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which port wins next, which port is holding the bus, and the
    // ordered list of ports still waiting for a response.
    int m_rr;
    int m_lock;
    int m_q[$];
    bit m_err_exp;

    int e_g;
    bit e_sreq, e_acc, e_pop, e_errn;

    typedef struct {
        logic        p0r, p1r, ack;
        logic [1:0]  resp;
        logic        esreq, eack0, eack1;
        logic [31:0] eaddr;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr      = 0;
        m_lock    = -1;
        m_err_exp = 1'b0;
    endtask

    task automatic drive(input bit r0, input bit r1, input bit ack, input logic [1:0] resp);
        p0_req    = r0;
        p1_req    = r1;
        s_req_ack = ack;
        s_resp    = resp;
        s_rdata   = $urandom;
        p0_cmd    = 1'($urandom_range(0, 1));
        p1_cmd    = 1'($urandom_range(0, 1));
        p0_width  = 2'($urandom_range(0, 2));
        p1_width  = 2'($urandom_range(0, 2));
        p0_wdata  = $urandom;
        p1_wdata  = $urandom;
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic settle_check();
        logic        req_g;
        logic [34:0] e_fields;
        logic [1:0]  e_r0, e_r1;
        logic [31:0] e_d0, e_d1;
        #2;
        if (m_lock >= 0)          e_g = m_lock;
        else if (p0_req && p1_req) e_g = m_rr;
        else if (p0_req)           e_g = 0;
        else if (p1_req)           e_g = 1;
        else                       e_g = -1;
        req_g    = (e_g == 0) ? p0_req : (e_g == 1) ? p1_req : 1'b0;
        e_sreq   = req_g && (m_q.size() < DEPTH);
        e_acc    = e_sreq && s_req_ack;
        e_fields = (e_g == 0) ? {p0_cmd, p0_width, p0_addr} :
                   (e_g == 1) ? {p1_cmd, p1_width, p1_addr} : '0;
        e_pop    = (s_resp != 2'b00) && (m_q.size() > 0);
        e_errn   = (s_resp != 2'b00) && (m_q.size() == 0);
        e_r0 = 2'b00; e_r1 = 2'b00; e_d0 = '0; e_d1 = '0;
        if (e_pop && m_q[0] == 0) begin e_r0 = s_resp; e_d0 = s_rdata; end
        if (e_pop && m_q[0] == 1) begin e_r1 = s_resp; e_d1 = s_rdata; end
        chk("s_req", s_req, e_sreq);
        chk("s_fields", {s_cmd, s_width, s_addr}, e_fields);
        chk("s_wdata", s_wdata, (e_g == 0) ? p0_wdata : (e_g == 1) ? p1_wdata : 32'h0);
        chk("p0_req_ack", p0_req_ack, e_acc && e_g == 0);
        chk("p1_req_ack", p1_req_ack, e_acc && e_g == 1);
        chk("p0_resp", {p0_resp, p0_rdata}, {e_r0, e_d0});
        chk("p1_resp", {p1_resp, p1_rdata}, {e_r1, e_d1});
        chk("arb_err", arb_err, m_err_exp);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (e_pop) void'(m_q.pop_front());
        if (e_acc) begin
            m_q.push_back(e_g);
            m_rr = 1 - e_g;
        end
        m_lock    = (e_sreq && !s_req_ack) ? e_g : -1;
        m_err_exp = e_errn;
        #1;
    endtask

    task automatic step(input bit r0, input bit r1, input bit ack, input logic [1:0] resp);
        drive(r0, r1, ack, resp);
        settle_check();
        clock_edge();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_out"}, {s_req, s_cmd, s_width, s_addr, s_wdata, p0_req_ack, p1_req_ack},
            '0);
        chk({nm, "_resp"}, {p0_resp, p1_resp, p0_rdata, p1_rdata}, '0);
        chk({nm, "_err"}, arb_err, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 32'h100};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h200};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 32'h100};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h100};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h100};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h100};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 32'h100};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h000};

        rst_n   = 1'b0;
        p0_addr = 32'h200;
        p1_addr = 32'h100;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        model_reset();

        // Outputs stay quiet under reset even with live requests and a response.
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b1, 2'b01);
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        #1;

        // Alternating grants, then a stalled p1 keeping the bus while p0 waits.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].p0r, tbl[i].p1r, tbl[i].ack, tbl[i].resp);
            settle_check();
            chk($sformatf("tbl%0d_s_req", i), s_req, tbl[i].esreq);
            chk($sformatf("tbl%0d_acks", i), {p0_req_ack, p1_req_ack},
                {tbl[i].eack0, tbl[i].eack1});
            chk($sformatf("tbl%0d_s_addr", i), s_addr, tbl[i].eaddr);
            $display("tbl %0d: s_req=%0b ack0=%0b ack1=%0b s_addr=%h", i, s_req, p0_req_ack,
                     p1_req_ack, s_addr);
            clock_edge();
        end

        // Full FIFO blocks a third request, even in the cycle that pops.
        step(1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        settle_check();
        chk("full_block", s_req, 1'b0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b1, 2'b01);
        settle_check();
        chk("full_pop_block", s_req, 1'b0);
        chk("full_pop_resp", p0_resp, 2'b01);
        clock_edge();
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        settle_check();
        chk("after_pop_accept", {s_req, p0_req_ack}, 2'b11);
        clock_edge();
        step(1'b0, 1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b0, 1'b0, 2'b01);
        $display("case3 done: checks=%0d", checks);

        // In-order routing of OK then ER.
        step(1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 2'b01);
        s_rdata = 32'h0000_AAAA;
        settle_check();
        chk("route_ok", {p0_resp, p0_rdata, p1_resp}, {2'b01, 32'h0000_AAAA, 2'b00});
        clock_edge();
        drive(1'b0, 1'b0, 1'b0, 2'b10);
        settle_check();
        chk("route_er", {p1_resp, p0_resp}, {2'b10, 2'b00});
        clock_edge();
        $display("case4 done: checks=%0d", checks);

        // Response with nothing outstanding.
        drive(1'b0, 1'b0, 1'b0, 2'b01);
        settle_check();
        chk("orphan_drop", {p0_resp, p1_resp}, 4'b0000);
        clock_edge();
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        settle_check();
        chk("orphan_err_pulse", arb_err, 1'b1);
        clock_edge();
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        settle_check();
        chk("orphan_err_clear", arb_err, 1'b0);
        clock_edge();
        $display("case5 done: checks=%0d", checks);

        // Reset with two requests outstanding.
        step(1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        drive(1'b0, 1'b0, 1'b0, 2'b01);
        settle_check();
        chk("post_reset_drop", {p0_resp, p1_resp}, 4'b0000);
        clock_edge();
        drive(1'b1, 1'b1, 1'b1, 2'b00);
        settle_check();
        chk("post_reset_err", arb_err, 1'b1);
        chk("post_reset_rr0", {p0_req_ack, p1_req_ack}, 2'b10);
        clock_edge();
        step(1'b0, 1'b0, 1'b0, 2'b01);
        $display("case6 done: checks=%0d", checks);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [1:0] resp;
            resp = 2'b00;
            if (m_q.size() > 0) begin
                if ($urandom_range(0, 9) < 4) resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
            end else if ($urandom_range(0, 29) == 0) begin
                resp = 2'b01;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), resp);
            p0_addr = $urandom;
            p1_addr = $urandom;
            settle_check();
            clock_edge();
        end
        $display("random done: checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
